// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module   : if_stage_pkg
// Brief    : Shared constants and counter helper for the RV32I fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;

    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != BHT_ST)
            nxt = cnt + 2'd1;
        else if (!taken && cnt != BHT_SNT)
            nxt = cnt - 2'd1;
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_if.sv
// ============================================================================
// Module   : if_stage_if
// Brief    : Signal bundle between the fetch stage and its neighbours
//            (hazard unit, decode, execute, instruction memory).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface if_stage_if;

    logic        stall_IF;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] pc_nxt;
    logic        bht_upd_en;
    logic [31:0] bht_upd_pc;
    logic        bht_upd_taken;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_IF;
    logic [31:0] pc_4_IF;
    logic [31:0] ir_IF;
    logic        predict;

    // The fetch stage itself
    modport master (
        input  stall_IF, redirect_en, redirect_pc, pc_nxt,
        input  bht_upd_en, bht_upd_pc, bht_upd_taken,
        input  imem_data,
        output imem_addr, pc_IF, pc_4_IF, ir_IF, predict
    );

    // Surrounding pipeline and memory
    modport slave (
        output stall_IF, redirect_en, redirect_pc, pc_nxt,
        output bht_upd_en, bht_upd_pc, bht_upd_taken,
        output imem_data,
        input  imem_addr, pc_IF, pc_4_IF, ir_IF, predict
    );

endinterface

`default_nettype wire

// File: rtl/if_stage_bht.sv
// ============================================================================
// Module   : bht
// Brief    : Untagged table of 2-bit saturating direction counters with one
//            read port and one update port; reads see pre-update contents.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bht
    import if_stage_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [IDX_W-1:0] rd_idx,
    output logic                  rd_taken,
    input  wire logic             upd_en,
    input  wire logic [IDX_W-1:0] upd_idx,
    input  wire logic             upd_taken
);

    localparam int c_ENTRIES = 1 << IDX_W;

    logic [1:0] r_cnt [c_ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++)
                r_cnt[i] <= BHT_WNT;
        end else if (upd_en) begin
            r_cnt[upd_idx] <= bht_next(r_cnt[upd_idx], upd_taken);
        end
    end

    assign rd_taken = r_cnt[rd_idx][1];

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : RV32I instruction-fetch stage: fetch-address select, IF pipeline
//            registers and optional branch-direction predictor (IF_BHT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BHT_IDX_W = 6
) (
    input  wire logic   clk,
    input  wire logic   rst,
    if_stage_if.master  bus
);

    logic [31:0] w_imem_addr;
    logic        w_lookup;
    logic        w_load;

    logic [31:0] r_pc;
    logic [31:0] r_pc_4;
    logic [31:0] r_ir;
    logic        r_predict;

    assign w_imem_addr = bus.redirect_en ? bus.redirect_pc : bus.pc_nxt;
    // A redirect flushes the stalled consumer, so it overrides the hold
    assign w_load      = bus.redirect_en | ~bus.stall_IF;

`ifdef IF_BHT_EN
    logic w_unused;
    assign w_unused = ^{bus.bht_upd_pc[31:BHT_IDX_W+2], bus.bht_upd_pc[1:0]};

    bht #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (w_imem_addr[BHT_IDX_W+1:2]),
        .rd_taken  (w_lookup),
        .upd_en    (bus.bht_upd_en),
        .upd_idx   (bus.bht_upd_pc[BHT_IDX_W+1:2]),
        .upd_taken (bus.bht_upd_taken)
    );
`else
    logic w_unused;
    assign w_unused = ^{bus.bht_upd_en, bus.bht_upd_pc, bus.bht_upd_taken};
    assign w_lookup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC - 32'd4;
            r_pc_4    <= RESET_PC;
            r_ir      <= NOP_INSN;
            r_predict <= 1'b0;
        end else if (w_load) begin
            r_pc      <= w_imem_addr;
            r_pc_4    <= w_imem_addr + 32'd4;
            r_ir      <= bus.imem_data;
            r_predict <= w_lookup;
        end
    end

    assign bus.imem_addr = w_imem_addr;
    assign bus.pc_IF     = r_pc;
    assign bus.pc_4_IF   = r_pc_4;
    assign bus.ir_IF     = r_ir;
    assign bus.predict   = r_predict;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Brief    : Directed plus randomized bench for if_stage against a
//            behavioural model; honours IF_BHT_EN like the design.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;
    localparam int          c_IDX_W    = 6;
    localparam int          c_NENT     = 1 << c_IDX_W;
`ifdef IF_BHT_EN
    localparam bit          c_BHT      = 1'b1;
`else
    localparam bit          c_BHT      = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference state
    logic [31:0] m_pc, m_pc4, m_ir;
    logic        m_pred;
    int          m_cnt [c_NENT];

    if_stage_if bus ();

    if_stage #(
        .RESET_PC  (c_RESET_PC),
        .BHT_IDX_W (c_IDX_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'((a / 4) % c_NENT);
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("pc_IF",   bus.pc_IF,   m_pc);
        chk("pc_4_IF", bus.pc_4_IF, m_pc4);
        chk("ir_IF",   bus.ir_IF,   m_ir);
        chk("predict", {31'd0, bus.predict}, {31'd0, m_pred});
    endtask

    task automatic model_reset();
        m_pc   = c_RESET_PC - 32'd4;
        m_pc4  = c_RESET_PC;
        m_ir   = 32'h0000_0013;
        m_pred = 1'b0;
        for (int i = 0; i < c_NENT; i++) m_cnt[i] = 1;
    endtask

    task automatic do_reset(input logic ue, input logic [31:0] upc, input logic ut);
        @(negedge clk);
        rst               = 1'b1;
        bus.stall_IF      = 1'b0;
        bus.redirect_en   = 1'b0;
        bus.bht_upd_en    = ue;
        bus.bht_upd_pc    = upc;
        bus.bht_upd_taken = ut;
        @(posedge clk);
        #1;
        model_reset();
        chk_outputs();
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic [31:0] pcn, input logic ue,
                        input logic [31:0] upc, input logic ut);
        logic [31:0] a;
        int          i;
        @(negedge clk);
        rst               = 1'b0;
        bus.stall_IF      = st;
        bus.redirect_en   = rd;
        bus.redirect_pc   = rpc;
        bus.pc_nxt        = pcn;
        bus.bht_upd_en    = ue;
        bus.bht_upd_pc    = upc;
        bus.bht_upd_taken = ut;
        a = rd ? rpc : pcn;
        #1;
        chk("imem_addr", bus.imem_addr, a);
        // Lookup is taken before this cycle's training lands
        if (rd || !st) begin
            m_pc   = a;
            m_pc4  = a + 32'd4;
            m_ir   = mem_word(a);
            m_pred = c_BHT && (m_cnt[idx(a)] >= 2);
        end
        if (c_BHT && ue) begin
            i = idx(upc);
            if (ut) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
            else    m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
        @(posedge clk);
        #1;
        chk_outputs();
    endtask

    task automatic fetch(input logic [31:0] a);
        step(1'b0, 1'b0, 32'h0, a, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic train(input logic [31:0] a, input logic t);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, a, t);
    endtask

    initial begin
        logic [31:0] ra, rb, rc;
        bus.stall_IF = 1'b0; bus.redirect_en = 1'b0; bus.redirect_pc = '0;
        bus.pc_nxt = '0; bus.bht_upd_en = 1'b0; bus.bht_upd_pc = '0;
        bus.bht_upd_taken = 1'b0;
        model_reset();

        // Reset, then decode feeds pc_4_IF back as pc_nxt
        do_reset(1'b0, 32'h0, 1'b0);
        do_reset(1'b1, 32'h40, 1'b1);
        chk("rst_ir", bus.ir_IF, 32'h0000_0013);
        chk("rst_pc4", bus.pc_4_IF, 32'h0000_0100);
        fetch(bus.pc_4_IF);
        chk("boot_pc", bus.pc_IF, 32'h0000_0100);

        // Sequential fetch with a two-cycle stall at 0x4
        fetch(32'h0);
        fetch(32'h4);
        step(1'b1, 1'b0, 32'h0, 32'h8, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h8, 1'b0, 32'h0, 1'b0);
        chk("stall_hold", bus.pc_IF, 32'h4);
        fetch(32'h8);
        chk("after_stall", bus.pc_IF, 32'h8);

        // Redirect overrides stall
        step(1'b1, 1'b1, 32'h200, 32'hC, 1'b0, 32'h0, 1'b0);
        chk("redir_pc", bus.pc_IF, 32'h200);
        chk("redir_ir", bus.ir_IF, mem_word(32'h200));

        // Training, aliasing and saturation
        train(32'h40, 1'b1);
        train(32'h40, 1'b1);
        fetch(32'h40);
        chk("trained", {31'd0, bus.predict}, {31'd0, c_BHT});
        fetch(32'h40 + 32'(4 * c_NENT));
        chk("alias", {31'd0, bus.predict}, {31'd0, c_BHT});
        for (int k = 0; k < 4; k++) train(32'h40, 1'b0);
        train(32'h40, 1'b1);
        fetch(32'h40);
        chk("sat_low", {31'd0, bus.predict}, 32'd0);

        // Same-cycle lookup and update: no bypass
        step(1'b0, 1'b0, 32'h0, 32'h40, 1'b1, 32'h40, 1'b1);
        chk("no_bypass", {31'd0, bus.predict}, 32'd0);
        fetch(32'h40);
        chk("post_upd", {31'd0, bus.predict}, {31'd0, c_BHT});

        // Mid-run reset with a concurrent update discarded
        train(32'h40, 1'b1);
        do_reset(1'b1, 32'h40, 1'b1);
        fetch(32'h40);
        chk("rst_clears", {31'd0, bus.predict}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_03FC);
            rb = $urandom & 32'h0000_03FC;
            rc = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_03FC);
            if ($urandom_range(0, 49) == 0)
                do_reset($urandom_range(0, 1) == 1, rc, $urandom_range(0, 1) == 1);
            else
                step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, rb, ra,
                     $urandom_range(0, 4) < 2, rc, $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
